i2c_pkt_buf: RTL and testbench

Parametrised packet buffer between the Wishbone bus and the I2C slave PHY, successor to the fixed 256×32 I2C bridge. It holds TX and RX FIFOs of configurable width and depth, gates PHY traffic in whole packets of `PKG_LEN` words, and adds threshold and watermark interrupts, sticky overflow/underflow flags and an optional RX timeout. It sits between the CPU Wishbone interconnect and `i2c_phy`; the PHY drives its own pins.

---
 rtl/i2c_pkt_pkg.sv | 37 +++
 rtl/i2c_sync_fifo.sv | 67 ++++++
 rtl/i2c_pkt_buf.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_pkt_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkt_pkg.sv
// Shared register map, CTRL/STAT bit positions and sticky-flag indices for i2c_pkt_buf.
package i2c_pkt_pkg;

    localparam logic [5:0] ADR_CTRL   = 6'h00;
    localparam logic [5:0] ADR_ADDR   = 6'h04;
    localparam logic [5:0] ADR_TX     = 6'h08;
    localparam logic [5:0] ADR_RX     = 6'h0C;
    localparam logic [5:0] ADR_THRESH = 6'h10;
    localparam logic [5:0] ADR_TMO    = 6'h14;

    localparam int unsigned CTRL_SRST    = 0;
    localparam int unsigned CTRL_TXFL    = 1;
    localparam int unsigned CTRL_RXFL    = 2;
    localparam int unsigned CTRL_EN_LSB  = 3;
    localparam int unsigned CTRL_W1C_LSB = 8;

    localparam int unsigned NUM_EN     = 3;
    localparam int unsigned NUM_STICKY = 6;

    localparam logic [31:0] RD_DEFAULT = 32'hDEADDEAD;

    typedef enum logic [1:0] {
        EN_RX  = 2'd0,
        EN_TX  = 2'd1,
        EN_ERR = 2'd2
    } en_e;

    typedef enum logic [2:0] {
        STK_WSTOP  = 3'd0,
        STK_RSTOP  = 3'd1,
        STK_RERR   = 3'd2,
        STK_RX_OVF = 3'd3,
        STK_TX_OVF = 3'd4,
        STK_RX_TMO = 3'd5
    } sticky_e;

endpackage

// File: rtl/i2c_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, occupancy count and
// overflow/underflow pulses; holds the last popped head while empty.
module i2c_sync_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_c,
    output logic [CW-1:0] count_o,
    output logic          ovf_c,
    output logic          udf_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [DW-1:0] last_q;
    logic          empty_c;
    logic          full_c;
    logic          pop_ok_c;
    logic          push_ok_c;

    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CW'(DEPTH));
    assign pop_ok_c  = pop_i & ~empty_c;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok_c = push_i & (~full_c | pop_ok_c);

    assign ovf_c   = push_i & ~push_ok_c & ~flush_i;
    assign udf_c   = pop_i & empty_c & ~flush_i;
    assign dout_c  = empty_c ? last_q : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            count_q <= count_q + CW'(push_ok_c) - CW'(pop_ok_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && !flush_i && push_ok_c) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/i2c_pkt_buf.sv
// Wishbone-to-I2C-PHY packet buffer: TX/RX FIFOs, packet gating, interrupts.
// Optional RX timeout is built when I2C_RX_TIMEOUT_EN is defined.
module i2c_pkt_buf
    import i2c_pkt_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned PKG_LEN = 10,
    parameter int unsigned CW      = $clog2(DEPTH) + 1,
    parameter int unsigned TMO_W   = 16
) (
    input  logic          CLK_I,
    input  logic          RST_N_I,
    input  logic          I2C_STB_I,
    input  logic          I2C_WE_I,
    input  logic [5:0]    I2C_ADR_I,
    input  logic [31:0]   I2C_DAT_I,
    output logic          I2C_ACK_O,
    output logic [31:0]   I2C_DAT_O,
    input  logic          phy_push,
    input  logic [DW-1:0] phy_din,
    output logic          phy_full,
    input  logic          phy_pop,
    output logic [DW-1:0] phy_dout,
    output logic          phy_empty,
    input  logic          phy_wstop,
    input  logic          phy_rstop,
    input  logic          phy_rerr,
    output logic [6:0]    reg_addr_o,
    output logic          int_o
);

    logic                  ack_q;
    logic [31:0]           dat_q, dat_d;
    logic                  int_q, int_d;
    logic [6:0]            addr_q, addr_d;
    logic [15:0]           rx_thr_q, rx_thr_d;
    logic [15:0]           tx_wm_q, tx_wm_d;
    logic [NUM_EN-1:0]     en_q, en_d;
    logic [NUM_STICKY-1:0] sticky_q, sticky_d;
    logic                  rx_udf_q, rx_udf_d;
    logic                  tx_udf_q, tx_udf_d;

    logic          acc_c, wr_c, rd_c, ctrl_wr_c, srst_c;
    logic          tx_flush_c, rx_flush_c, tx_push_c, rx_pop_c;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [DW-1:0] rx_head;
    logic          tx_ovf_c, tx_udf_c, rx_ovf_c, rx_udf_c;
    logic [31:0]   rdata_c;

    assign acc_c      = I2C_STB_I & ~ack_q;
    assign wr_c       = acc_c & I2C_WE_I;
    assign rd_c       = acc_c & ~I2C_WE_I;
    assign ctrl_wr_c  = wr_c & (I2C_ADR_I == ADR_CTRL);
    assign srst_c     = ctrl_wr_c & I2C_DAT_I[CTRL_SRST];
    assign tx_flush_c = srst_c | (ctrl_wr_c & I2C_DAT_I[CTRL_TXFL]);
    assign rx_flush_c = srst_c | (ctrl_wr_c & I2C_DAT_I[CTRL_RXFL]);
    assign tx_push_c  = wr_c & (I2C_ADR_I == ADR_TX);
    assign rx_pop_c   = rd_c & (I2C_ADR_I == ADR_RX);

    i2c_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
        .clk_i   (CLK_I),
        .rst_n_i (RST_N_I),
        .flush_i (tx_flush_c),
        .push_i  (tx_push_c),
        .din_i   (DW'(I2C_DAT_I)),
        .pop_i   (phy_pop),
        .dout_c  (phy_dout),
        .count_o (tx_cnt),
        .ovf_c   (tx_ovf_c),
        .udf_c   (tx_udf_c)
    );

    i2c_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
        .clk_i   (CLK_I),
        .rst_n_i (RST_N_I),
        .flush_i (rx_flush_c),
        .push_i  (phy_push),
        .din_i   (phy_din),
        .pop_i   (rx_pop_c),
        .dout_c  (rx_head),
        .count_o (rx_cnt),
        .ovf_c   (rx_ovf_c),
        .udf_c   (rx_udf_c)
    );

    // Packet gating: PHY only moves whole packets.
    assign phy_full  = (32'(rx_cnt) + PKG_LEN) > DEPTH;
    assign phy_empty = 32'(tx_cnt) < PKG_LEN;

`ifdef I2C_RX_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_dec_c;

    assign tmo_dec_c = (rx_cnt != '0) && (32'(rx_cnt) < 32'(rx_thr_q)) &&
                       (tmo_q != '0) && (tcnt_q != '0);

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            tmo_q  <= '0;
            tcnt_q <= '0;
        end else begin
            tmo_q  <= tmo_d;
            tcnt_q <= tcnt_d;
        end
    end
`endif

    always_comb begin
        rdata_c = RD_DEFAULT;
        case (I2C_ADR_I)
            ADR_CTRL:   rdata_c = 32'({en_q, sticky_q, rx_udf_q, tx_udf_q, tx_cnt, rx_cnt});
            ADR_ADDR:   rdata_c = 32'(addr_q);
            ADR_TX:     rdata_c = 32'd0;
            ADR_RX:     rdata_c = 32'(rx_head);
            ADR_THRESH: rdata_c = {tx_wm_q, rx_thr_q};
`ifdef I2C_RX_TIMEOUT_EN
            ADR_TMO:    rdata_c = 32'(tmo_q);
`else
            ADR_TMO:    rdata_c = 32'({TMO_W{1'b0}});
`endif
            default:    rdata_c = RD_DEFAULT;
        endcase
    end

    always_comb begin
        dat_d    = dat_q;
        addr_d   = addr_q;
        rx_thr_d = rx_thr_q;
        tx_wm_d  = tx_wm_q;
        en_d     = en_q;
        sticky_d = sticky_q;
        rx_udf_d = rx_udf_q | rx_udf_c;
        tx_udf_d = tx_udf_q | tx_udf_c;
`ifdef I2C_RX_TIMEOUT_EN
        tmo_d    = tmo_q;
        tcnt_d   = tcnt_q;
`endif

        // Soft reset keeps configuration, so enables and W1C apply only without it.
        if (ctrl_wr_c && !I2C_DAT_I[CTRL_SRST]) begin
            en_d     = I2C_DAT_I[CTRL_EN_LSB +: NUM_EN];
            sticky_d = sticky_q & ~I2C_DAT_I[CTRL_W1C_LSB +: NUM_STICKY];
        end
        if (wr_c && I2C_ADR_I == ADR_ADDR) addr_d = I2C_DAT_I[6:0];
        if (wr_c && I2C_ADR_I == ADR_THRESH) begin
            rx_thr_d = I2C_DAT_I[15:0];
            tx_wm_d  = I2C_DAT_I[31:16];
        end
        if (rd_c) dat_d = rdata_c;

        sticky_d[STK_WSTOP]  = sticky_d[STK_WSTOP]  | phy_wstop;
        sticky_d[STK_RSTOP]  = sticky_d[STK_RSTOP]  | phy_rstop;
        sticky_d[STK_RERR]   = sticky_d[STK_RERR]   | phy_rerr;
        sticky_d[STK_RX_OVF] = sticky_d[STK_RX_OVF] | rx_ovf_c;
        sticky_d[STK_TX_OVF] = sticky_d[STK_TX_OVF] | tx_ovf_c;

`ifdef I2C_RX_TIMEOUT_EN
        if (wr_c && I2C_ADR_I == ADR_TMO) tmo_d = I2C_DAT_I[TMO_W-1:0];
        if (phy_push || rx_pop_c) begin
            tcnt_d = tmo_q;
        end else if (tmo_dec_c) begin
            tcnt_d = tcnt_q - TMO_W'(1);
            if (tcnt_q == TMO_W'(1)) sticky_d[STK_RX_TMO] = 1'b1;
        end
        if (srst_c) tcnt_d = '0;
`endif

        if (srst_c) begin
            sticky_d = '0;
            rx_udf_d = 1'b0;
            tx_udf_d = 1'b0;
        end

        int_d = (en_q[EN_RX] && rx_thr_q != 16'd0 && 32'(rx_cnt) >= 32'(rx_thr_q)) ||
                (en_q[EN_TX] && 32'(tx_cnt) <= 32'(tx_wm_q)) ||
                (en_q[EN_ERR] && (sticky_q[STK_RX_OVF] || sticky_q[STK_TX_OVF] ||
                                  sticky_q[STK_RERR] || sticky_q[STK_RX_TMO]));
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_N_I) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            int_q    <= 1'b0;
            addr_q   <= '0;
            rx_thr_q <= '0;
            tx_wm_q  <= '0;
            en_q     <= '0;
            sticky_q <= '0;
            rx_udf_q <= 1'b0;
            tx_udf_q <= 1'b0;
        end else begin
            ack_q    <= acc_c;
            dat_q    <= dat_d;
            int_q    <= int_d;
            addr_q   <= addr_d;
            rx_thr_q <= rx_thr_d;
            tx_wm_q  <= tx_wm_d;
            en_q     <= en_d;
            sticky_q <= sticky_d;
            rx_udf_q <= rx_udf_d;
            tx_udf_q <= tx_udf_d;
        end
    end

    assign I2C_ACK_O  = ack_q;
    assign I2C_DAT_O  = dat_q;
    assign int_o      = int_q;
    assign reg_addr_o = addr_q;

endmodule

// File: tb/tb_i2c_pkt_buf.sv
// Directed bench for i2c_pkt_buf (DEPTH=256, PKG_LEN=10); define I2C_RX_TIMEOUT_EN to cover the timeout.
module tb_i2c_pkt_buf;

    localparam int unsigned DW      = 32;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned PKG_LEN = 10;
    localparam int unsigned CW      = 9;
    localparam int unsigned TMO_W   = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stb, we;
    logic [5:0]    adr;
    logic [31:0]   dati;
    logic          ack;
    logic [31:0]   dato;
    logic          push;
    logic [DW-1:0] din;
    logic          full;
    logic          pop;
    logic [DW-1:0] dout;
    logic          empty;
    logic          wstop, rstop, rerr;
    logic [6:0]    saddr;
    logic          irq;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] rd;
    logic        rd_ack;

    i2c_pkt_buf #(.DW(DW), .DEPTH(DEPTH), .PKG_LEN(PKG_LEN), .CW(CW), .TMO_W(TMO_W)) dut (
        .CLK_I      (clk),
        .RST_N_I    (rst_n),
        .I2C_STB_I  (stb),
        .I2C_WE_I   (we),
        .I2C_ADR_I  (adr),
        .I2C_DAT_I  (dati),
        .I2C_ACK_O  (ack),
        .I2C_DAT_O  (dato),
        .phy_push   (push),
        .phy_din    (din),
        .phy_full   (full),
        .phy_pop    (pop),
        .phy_dout   (dout),
        .phy_empty  (empty),
        .phy_wstop  (wstop),
        .phy_rstop  (rstop),
        .phy_rerr   (rerr),
        .reg_addr_o (saddr),
        .int_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Expected CTRL/STAT word: {en, sticky, rx_udf, tx_udf, tx_count, rx_count} with CW=9.
    function automatic logic [31:0] stat(input int en, input int stk, input int rxu,
                                         input int txu, input int tx, input int rx);
        return (32'(en) << 26) | (32'(stk) << 20) | (32'(rxu) << 19) |
               (32'(txu) << 18) | (32'(tx) << 9) | 32'(rx);
    endfunction

    task automatic wb_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk); stb = 1'b1; we = 1'b1; adr = a; dati = d;
        @(negedge clk); stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk); stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk); stb = 1'b0; d = dato; rd_ack = ack;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); push = 1'b1; din = base + 32'(i);
        end
        @(negedge clk); push = 1'b0;
    endtask

    task automatic pop_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); pop = 1'b1;
        end
        @(negedge clk); pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dati = '0;
        push = 1'b0; din = '0; pop = 1'b0; wstop = 1'b0; rstop = 1'b0; rerr = 1'b0;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dato", dato, 32'd0);
        check("rst_int", 32'(irq), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_saddr", 32'(saddr), 32'd0);

        // TX packet gating
        for (int i = 0; i < 9; i++) wb_write(6'h08, 32'h100 + 32'(i));
        check("tx9_empty", 32'(empty), 32'd1);
        wb_write(6'h08, 32'h109);
        @(negedge clk);
        check("tx10_empty", 32'(empty), 32'd0);
        wb_read(6'h00, rd);
        check("tx10_stat", rd, stat(0, 0, 0, 0, 10, 0));
        check("tx_head", dout, 32'h100);
        pop_words(10);
        check("tx_last_head", dout, 32'h109);
        pop_words(1);
        check("tx_udf_dout", dout, 32'h109);
        wb_read(6'h00, rd);
        check("tx_udf_stat", rd, stat(0, 0, 0, 1, 0, 0));

        // Configuration registers and unmapped read
        wb_write(6'h04, 32'h55);
        check("saddr", 32'(saddr), 32'h55);
        wb_read(6'h04, rd);
        check("addr_rd", rd, 32'h55);
        check("addr_ack", 32'(rd_ack), 32'd1);
        wb_write(6'h10, 32'h0000_0004);
        wb_read(6'h10, rd);
        check("thresh_rd", rd, 32'h4);
        wb_read(6'h18, rd);
        check("unmapped", rd, 32'hDEADDEAD);

        // RX threshold interrupt
        wb_write(6'h00, 32'h08);
        wb_read(6'h00, rd);
        check("en_stat", rd, stat(1, 0, 0, 1, 0, 0));
        push_words(3, 32'hA0);
        push_words(1, 32'hA3);
        check("int_pre", 32'(irq), 32'd0);
        @(negedge clk);
        check("int_rise", 32'(irq), 32'd1);
        wb_read(6'h0C, rd);
        check("rx_head", rd, 32'hA0);
        @(negedge clk);
        check("int_fall", 32'(irq), 32'd0);

        // RX fill: phy_full boundary and overflow
        push_words(243, 32'h200);
        check("full_246", 32'(full), 32'd0);
        push_words(1, 32'h300);
        check("full_247", 32'(full), 32'd1);
        push_words(10, 32'h301);
        wb_read(6'h00, rd);
        check("rx_ovf_stat", rd, stat(1, 8, 0, 1, 0, 256));

        // Push and pop together while full
        wb_write(6'h00, 32'h0000_0808);
        @(negedge clk); stb = 1'b1; we = 1'b0; adr = 6'h0C; push = 1'b1; din = 32'h3FF;
        @(negedge clk); stb = 1'b0; push = 1'b0; rd = dato;
        check("full_pp_data", rd, 32'hA1);
        wb_read(6'h00, rd);
        check("full_pp_stat", rd, stat(1, 0, 0, 1, 0, 256));

        @(negedge clk); wstop = 1'b1;
        @(negedge clk); wstop = 1'b0;
        wb_read(6'h00, rd);
        check("wstop_stat", rd, stat(1, 1, 0, 1, 0, 256));

        // Soft reset mid-transfer keeps configuration
        for (int i = 0; i < 3; i++) wb_write(6'h08, 32'h500 + 32'(i));
        wb_write(6'h00, 32'h1);
        wb_read(6'h00, rd);
        check("srst_stat", rd, stat(1, 0, 0, 0, 0, 0));
        check("srst_empty", 32'(empty), 32'd1);
        check("srst_full", 32'(full), 32'd0);
        wb_read(6'h04, rd);
        check("srst_addr", rd, 32'h55);
        wb_read(6'h10, rd);
        check("srst_thresh", rd, 32'h4);

        // Hard reset mid-packet
        push_words(4, 32'h600);
        @(negedge clk);
        check("pre_rst_int", 32'(irq), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("hrst_ack", 32'(ack), 32'd0);
        check("hrst_dato", dato, 32'd0);
        check("hrst_int", 32'(irq), 32'd0);
        check("hrst_saddr", 32'(saddr), 32'd0);
        check("hrst_empty", 32'(empty), 32'd1);
        check("hrst_full", 32'(full), 32'd0);
        wb_read(6'h00, rd);
        check("hrst_stat", rd, 32'd0);
        wb_read(6'h10, rd);
        check("hrst_thresh", rd, 32'd0);

`ifdef I2C_RX_TIMEOUT_EN
        wb_write(6'h10, 32'd8);
        wb_write(6'h14, 32'd100);
        push_words(3, 32'h700);
        repeat (98) @(negedge clk);
        wb_read(6'h00, rd);
        check("tmo_before", rd, stat(0, 0, 0, 0, 0, 3));
        wb_read(6'h00, rd);
        check("tmo_after", rd, stat(0, 32, 0, 0, 0, 3));
`else
        wb_write(6'h14, 32'd100);
        wb_read(6'h14, rd);
        check("tmo_absent", rd, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
